sys_bridge_n: RTL and testbench

//  Parametrised system bridge between CPU M-stage data port and NUM_TC timer windows, DM and the

---
 rtl/sys_bridge_n_pkg.sv | 17 +
 rtl/sys_bridge_n_if.sv | 17 +
 rtl/sys_bridge_n_irq_sync_edge.sv | 25 ++
 rtl/sys_bridge_n.sv | 131 +++++++++++++
 tb/tb_sys_bridge_n.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sys_bridge_n_pkg.sv
// Address map defaults, bus constants and decode helpers shared by the bridge files.
package sys_bridge_n_pkg;
  localparam logic [31:0] DM_END_DEF    = 32'h0000_2FFF;
  localparam logic [31:0] TC_BASE_DEF   = 32'h0000_7F00;
  localparam logic [31:0] TC_STRIDE_DEF = 32'h0000_0010;
  localparam logic [31:0] TC_SPAN_DEF   = 32'h0000_000C;
  localparam logic [31:0] INT_BASE_DEF  = 32'h0000_7F20;
  localparam logic [31:0] INT_LAST_OFS  = 32'h0000_0003;
  localparam int          HWINT_W       = 6;
  localparam logic [3:0]  BYTE_ALL      = 4'hF;

  // Inclusive window test; all windows are expressed as [lo, hi].
  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction
endpackage

// File: rtl/sys_bridge_n_if.sv
// CPU M-stage data port as seen by the system bridge.
interface sys_bridge_n_if;
  logic        pr_req;
  logic [31:0] pr_addr;
  logic [31:0] pr_wd;
  logic [3:0]  pr_we;
  logic [31:0] pr_rd;
  logic        pr_rd_valid;
  logic        pr_err;
  logic [31:0] err_addr;
  logic        err_clr;

  modport master (output pr_req, pr_addr, pr_wd, pr_we, err_clr,
                  input  pr_rd, pr_rd_valid, pr_err, err_addr);
  modport slave  (input  pr_req, pr_addr, pr_wd, pr_we, err_clr,
                  output pr_rd, pr_rd_valid, pr_err, err_addr);
endinterface

// File: rtl/sys_bridge_n_irq_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module sys_bridge_n_irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);
  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/sys_bridge_n.sv
// Address-decoding bridge from the CPU data port to DM, NUM_TC timers and the INT window,
// with registered read return, illegal-access reporting and external IRQ latching.
module sys_bridge_n
  import sys_bridge_n_pkg::*;
#(
  parameter int          NUM_TC    = 2,
  parameter logic [31:0] DM_END    = DM_END_DEF,
  parameter logic [31:0] TC_BASE   = TC_BASE_DEF,
  parameter logic [31:0] TC_STRIDE = TC_STRIDE_DEF,
  parameter logic [31:0] TC_SPAN   = TC_SPAN_DEF,
  parameter logic [31:0] INT_BASE  = INT_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  sys_bridge_n_if.slave          bus,
  output logic [31:0]            dev_wd,
  input  logic [31:0]            dm_rd,
  output logic [3:0]             dm_we,
  input  logic [32*NUM_TC-1:0]   tc_rd,
  output logic [NUM_TC-1:0]      tc_we,
  input  logic [NUM_TC-1:0]      tc_irq,
  input  logic                   ext_irq,
  output logic [HWINT_W-1:0]     hwint,
  output logic [31:0]            m_int_addr,
  output logic [3:0]             m_int_byteen
);
  logic              w_hit_dm;
  logic              w_hit_int;
  logic [NUM_TC-1:0] w_hit_tc;
  logic              w_any_tc;
  logic              w_unmapped;
  logic [31:0]       w_tc_rd_mask [NUM_TC];
  logic [31:0]       w_tc_rd;
  logic [31:0]       w_rd_sel;
  logic              w_is_read;
  logic              w_partial_tc;
  logic              w_illegal;
  logic              w_ack;
  logic              w_ext_rise;

  logic [31:0]       r_pr_rd;
  logic              r_pr_rd_valid;
  logic              r_pr_err;
  logic [31:0]       r_err_addr;
  logic              r_err_sticky;
  logic              r_ext_pend;

  assign w_hit_dm  = in_range(bus.pr_addr, 32'd0, DM_END);
  assign w_hit_int = in_range(bus.pr_addr, INT_BASE, INT_BASE + INT_LAST_OFS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TC; gi++) begin : g_tc
      localparam logic [31:0] LP_BASE = TC_BASE + TC_STRIDE * 32'(gi);
      assign w_hit_tc[gi]     = in_range(bus.pr_addr, LP_BASE, LP_BASE + TC_SPAN - 32'd1);
      assign w_tc_rd_mask[gi] = w_hit_tc[gi] ? tc_rd[32*gi +: 32] : 32'd0;
      // Timers only accept full-word writes; partial ones are reported as illegal.
      assign tc_we[gi]        = bus.pr_req & w_hit_tc[gi] & (bus.pr_we == BYTE_ALL);
    end
  endgenerate

  always_comb begin
    w_tc_rd = 32'd0;
    for (int k = 0; k < NUM_TC; k++) begin
      w_tc_rd = w_tc_rd | w_tc_rd_mask[k];
    end
  end

  assign w_any_tc     = |w_hit_tc;
  assign w_unmapped   = ~(w_hit_dm | w_any_tc | w_hit_int);
  assign w_rd_sel     = w_hit_dm ? dm_rd : (w_any_tc ? w_tc_rd : 32'd0);
  assign w_is_read    = bus.pr_req & (bus.pr_we == 4'd0);
  assign w_partial_tc = w_any_tc & (bus.pr_we != 4'd0) & (bus.pr_we != BYTE_ALL);
  assign w_illegal    = bus.pr_req & (w_unmapped | w_partial_tc);
  assign w_ack        = bus.pr_req & w_hit_int & (bus.pr_we != 4'd0);

  assign dev_wd       = bus.pr_wd;
  assign dm_we        = (bus.pr_req & w_hit_dm)  ? bus.pr_we   : 4'd0;
  assign m_int_addr   = (bus.pr_req & w_hit_int) ? bus.pr_addr : 32'd0;
  assign m_int_byteen = (bus.pr_req & w_hit_int) ? bus.pr_we   : 4'd0;

  sys_bridge_n_irq_sync_edge u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (ext_irq),
    .o_rise  (w_ext_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pr_rd       <= 32'd0;
      r_pr_rd_valid <= 1'b0;
      r_pr_err      <= 1'b0;
      r_err_addr    <= 32'd0;
      r_err_sticky  <= 1'b0;
      r_ext_pend    <= 1'b0;
    end else begin
      r_pr_err <= w_illegal;
      if (w_is_read) begin
        r_pr_rd       <= w_illegal ? 32'd0 : w_rd_sel;
        r_pr_rd_valid <= 1'b1;
      end else begin
        r_pr_rd_valid <= 1'b0;
      end
      // A clear arriving with a new error acts first, so the new error is captured.
      if (w_illegal && (!r_err_sticky || bus.err_clr)) begin
        r_err_addr   <= bus.pr_addr;
        r_err_sticky <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_addr   <= 32'd0;
        r_err_sticky <= 1'b0;
      end
      if (w_ext_rise) begin
        r_ext_pend <= 1'b1;
      end else if (w_ack) begin
        r_ext_pend <= 1'b0;
      end
    end
  end

  assign bus.pr_rd       = r_pr_rd;
  assign bus.pr_rd_valid = r_pr_rd_valid;
  assign bus.pr_err      = r_pr_err;
  assign bus.err_addr    = r_err_addr;

  always_comb begin
    hwint              = '0;
    hwint[NUM_TC-1:0]  = tc_irq;
    hwint[NUM_TC]      = r_ext_pend;
  end
endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed table-driven bench for sys_bridge_n with NUM_TC=2 and the default address map.
module tb_sys_bridge_n;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dev_wd;
  logic [31:0] dm_rd;
  logic [3:0]  dm_we;
  logic [63:0] tc_rd;
  logic [1:0]  tc_we;
  logic [1:0]  tc_irq;
  logic        ext_irq;
  logic [5:0]  hwint;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;

  int checks = 0;
  int failures = 0;

  sys_bridge_n_if bus ();

  sys_bridge_n #(.NUM_TC(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .dev_wd       (dev_wd),
    .dm_rd        (dm_rd),
    .dm_we        (dm_we),
    .tc_rd        (tc_rd),
    .tc_we        (tc_we),
    .tc_irq       (tc_irq),
    .ext_irq      (ext_irq),
    .hwint        (hwint),
    .m_int_addr   (m_int_addr),
    .m_int_byteen (m_int_byteen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [3:0]  e_dm_we;
    logic [1:0]  e_tc_we;
    logic [31:0] e_int_addr;
    logic [3:0]  e_int_be;
    logic        e_valid;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic [3:0] we,
                       input logic clr);
    bus.pr_req  = req;
    bus.pr_addr = addr;
    bus.pr_we   = we;
    bus.err_clr = clr;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'h0, 4'h0, 2'b00, 32'h0,    4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_7F14, 4'hF, 4'h0, 2'b10, 32'h0,    4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_7F14, 4'h3, 4'h0, 2'b00, 32'h0,    4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 4'h5, 2'b00, 32'h0,    4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_7F00, 4'h0, 4'h0, 2'b00, 32'h0,    4'h0, 1'b1, 32'hCAFE_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_7F10, 4'h0, 4'h0, 2'b00, 32'h0,    4'h0, 1'b1, 32'hCAFE_0001, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_4000, 4'h0, 4'h0, 2'b00, 32'h0,    4'h0, 1'b1, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h0000_2FFC, 4'h0, 4'h0, 2'b00, 32'h0,    4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_7F20, 4'h0, 4'h0, 2'b00, 32'h7F20, 4'h0, 1'b1, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0010, 4'hF, 4'h0, 2'b00, 32'h0,    4'h0, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h0000_7F30, 4'hF, 4'h0, 2'b00, 32'h0,    4'h0, 1'b0, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 32'h0000_0010, 4'h0, 4'h0, 2'b00, 32'h0,    4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_3000, 4'h0, 4'h0, 2'b00, 32'h0,    4'h0, 1'b1, 32'h0,         1'b1};
    vecs[13] = '{1'b1, 32'h0000_7F0B, 4'hF, 4'h0, 2'b01, 32'h0,    4'h0, 1'b0, 32'h0,         1'b0};
    vecs[14] = '{1'b1, 32'h0000_7F0C, 4'hF, 4'h0, 2'b00, 32'h0,    4'h0, 1'b0, 32'h0,         1'b1};
    vecs[15] = '{1'b1, 32'h0000_7F23, 4'h8, 4'h0, 2'b00, 32'h7F23, 4'h8, 1'b0, 32'h0,         1'b0};
    vecs[16] = '{1'b1, 32'h0000_2FFF, 4'h8, 4'h8, 2'b00, 32'h0,    4'h0, 1'b0, 32'h0,         1'b0};

    dm_rd   = 32'hDEAD_BEEF;
    tc_rd   = {32'hCAFE_0001, 32'hCAFE_0000};
    tc_irq  = 2'b00;
    ext_irq = 1'b0;
    bus.pr_wd = 32'h0;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    chk("reset_pr_rd", bus.pr_rd, 32'h0);
    chk("reset_valid", 32'(bus.pr_rd_valid), 32'h0);
    chk("reset_err", 32'(bus.pr_err), 32'h0);
    chk("reset_err_addr", bus.err_addr, 32'h0);
    chk("reset_hwint", 32'(hwint), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].we, 1'b0);
      bus.pr_wd = 32'h1234_5600 + 32'(i);
      #1;
      chk($sformatf("v%0d_dm_we", i), 32'(dm_we), 32'(vecs[i].e_dm_we));
      chk($sformatf("v%0d_tc_we", i), 32'(tc_we), 32'(vecs[i].e_tc_we));
      chk($sformatf("v%0d_int_addr", i), m_int_addr, vecs[i].e_int_addr);
      chk($sformatf("v%0d_int_be", i), 32'(m_int_byteen), 32'(vecs[i].e_int_be));
      chk($sformatf("v%0d_dev_wd", i), dev_wd, 32'h1234_5600 + 32'(i));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.pr_rd_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_rd", i), bus.pr_rd, vecs[i].e_rd);
      chk($sformatf("v%0d_err", i), 32'(bus.pr_err), 32'(vecs[i].e_err));
      $display("vec %0d req=%0b addr=%h we=%h rd=%h valid=%0b err=%0b", i, vecs[i].req,
               vecs[i].addr, vecs[i].we, bus.pr_rd, bus.pr_rd_valid, bus.pr_err);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    chk("sticky_first_err", bus.err_addr, 32'h7F14);

    // Error capture, stickiness and clear
    drive(1'b0, 32'h0, 4'h0, 1'b1);
    tick();
    chk("err_clr_addr", bus.err_addr, 32'h0);
    drive(1'b1, 32'h4000, 4'h0, 1'b0);
    tick();
    chk("err_4000_addr", bus.err_addr, 32'h4000);
    chk("err_4000_rd", bus.pr_rd, 32'h0);
    drive(1'b1, 32'h7F30, 4'hF, 1'b0);
    tick();
    chk("err_7f30_pulse", 32'(bus.pr_err), 32'h1);
    chk("err_7f30_sticky", bus.err_addr, 32'h4000);
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    chk("err_pulse_end", 32'(bus.pr_err), 32'h0);
    drive(1'b1, 32'h5000, 4'h0, 1'b1);
    tick();
    chk("err_clr_and_new", bus.err_addr, 32'h5000);
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    $display("err seq err_addr=%h", bus.err_addr);

    // Timer IRQ passthrough
    tc_irq = 2'b10;
    #1;
    chk("hwint_tc", 32'(hwint), 32'h02);
    tc_irq = 2'b00;
    #1;

    // External IRQ sync, set, ack, and set-wins-over-ack
    ext_irq = 1'b1;
    tick();
    chk("ext_edge1", 32'(hwint[2]), 32'h0);
    tick();
    chk("ext_edge2", 32'(hwint[2]), 32'h0);
    tick();
    chk("ext_edge3", 32'(hwint[2]), 32'h1);
    drive(1'b1, 32'h7F21, 4'b0010, 1'b0);
    #1;
    chk("ack_int_be", 32'(m_int_byteen), 32'h2);
    chk("ack_int_addr", m_int_addr, 32'h7F21);
    tick();
    chk("ack_clears", 32'(hwint[2]), 32'h0);
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    ext_irq = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    ext_irq = 1'b1;
    tick();
    tick();
    chk("pre_coincide", 32'(hwint[2]), 32'h0);
    drive(1'b1, 32'h7F20, 4'hF, 1'b0);
    tick();
    chk("set_wins", 32'(hwint[2]), 32'h1);
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    chk("pend_holds", 32'(hwint[2]), 32'h1);
    $display("irq seq hwint=%b", hwint);

    // Reset during a read drops it and clears pending state
    drive(1'b1, 32'h0000_0010, 4'h0, 1'b0);
    tick();
    chk("pre_reset_rd", bus.pr_rd, 32'hDEAD_BEEF);
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(bus.pr_rd_valid), 32'h0);
    chk("rst_mid_rd", bus.pr_rd, 32'h0);
    chk("rst_mid_hwint", 32'(hwint), 32'h0);
    $display("reset seq rd=%h valid=%0b hwint=%b", bus.pr_rd, bus.pr_rd_valid, hwint);
    reset = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
